// File: rtl/tensor_writer.sv
// Stream loader for the kernel's tensor memories: parses {id, len, data...} frames
// and issues one registered write strobe per accepted data word.
module tensor_writer #(
  parameter int WIDTH       = 16,
  parameter int NUM_TENSORS = 3,
  parameter int MAX_LEN     = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             kernel_busy,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_tensor_id,
  output logic [WIDTH-1:0] write_index,
  output logic [WIDTH-1:0] write_data,
  output logic             frame_done,
  output logic             frame_error
);

  localparam logic [1:0] HDR_ID  = 2'd0;
  localparam logic [1:0] HDR_LEN = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] NUM_T_W   = WIDTH'(NUM_TENSORS);
  localparam logic [WIDTH-1:0] MAX_LEN_W = WIDTH'(MAX_LEN);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] id_q, id_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             discard_q, discard_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wid_q, wid_d;
  logic [WIDTH-1:0] widx_q, widx_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             bad;

  // Ready depends only on state and kernel_busy so the source never sees a loop through in_valid.
  assign in_ready = !kernel_busy && (state_q != DONE);
  assign accept   = in_valid && in_ready;
  assign bad      = (id_q >= NUM_T_W) || (in_data > MAX_LEN_W);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    count_d   = count_q;
    discard_d = discard_q;
    err_d     = err_q;
    we_d      = 1'b0;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    case (state_q)
      HDR_ID: begin
        if (accept) begin
          id_d    = in_data;
          state_d = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (accept) begin
          len_d     = in_data;
          count_d   = '0;
          discard_d = bad;
          err_d     = bad;
          if (in_data == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // A rejected frame still drains its payload so the stream stays aligned.
        if (accept) begin
          if (!discard_q) begin
            we_d    = 1'b1;
            wid_d   = id_q;
            widx_d  = count_q;
            wdata_d = in_data;
          end
          count_d = count_q + ONE;
          if (count_q == len_q - ONE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = HDR_ID;
      default: state_d = HDR_ID;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HDR_ID;
      id_q      <= '0;
      len_q     <= '0;
      count_q   <= '0;
      discard_q <= 1'b0;
      we_q      <= 1'b0;
      wid_q     <= '0;
      widx_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      we_q      <= we_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign write_enable    = we_q;
  assign write_tensor_id = wid_q;
  assign write_index     = widx_q;
  assign write_data      = wdata_q;
  assign frame_done      = done_q;
  assign frame_error     = err_q;

endmodule

// File: tb/tb_tensor_writer.sv
// Bench for tensor_writer: drives framed streams and compares observed strobes, edges,
// frame_done and frame_error against a frame-level model of the loader.
module tb_tensor_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        kernel_busy;
  logic        write_enable;
  logic [15:0] write_tensor_id;
  logic [15:0] write_index;
  logic [15:0] write_data;
  logic        frame_done;
  logic        frame_error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] id;
    logic [15:0] idx;
    logic [15:0] data;
  } exp_t;

  int          acc_e[$];
  int          st_e[$];
  logic [15:0] st_id[$];
  logic [15:0] st_ix[$];
  logic [15:0] st_dt[$];
  int          dn_e[$];
  int          busy_cyc = 0;
  int          busy_rdy = 0;

  tensor_writer #(.WIDTH(16), .NUM_TENSORS(3), .MAX_LEN(6)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .kernel_busy(kernel_busy), .write_enable(write_enable),
    .write_tensor_id(write_tensor_id), .write_index(write_index), .write_data(write_data),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Observation log: an accept seen before edge k is stamped k; outputs seen after edge k are stamped k.
  always @(negedge clock) begin
    if (reset_n && in_valid && in_ready) acc_e.push_back(cyc + 1);
    if (write_enable) begin
      st_e.push_back(cyc);
      st_id.push_back(write_tensor_id);
      st_ix.push_back(write_index);
      st_dt.push_back(write_data);
    end
    if (frame_done) dn_e.push_back(cyc);
    if (kernel_busy) begin
      busy_cyc++;
      if (in_ready) busy_rdy++;
    end
  end

  task automatic clear_obs();
    acc_e.delete(); st_e.delete(); st_id.delete(); st_ix.delete(); st_dt.delete();
    dn_e.delete(); busy_cyc = 0; busy_rdy = 0;
  endtask

  // Frame-level reference: good frames write every payload word in order, bad ones write nothing.
  function automatic void model(input logic [15:0] w[$], output exp_t e[$], output logic err,
                                output int dpos);
    int n;
    n = int'(w[1]);
    e.delete();
    err = (w[0] >= 16'd3) || (w[1] > 16'd6);
    dpos = n + 1;
    if (!err) for (int i = 0; i < n; i++) e.push_back('{w[0], 16'(i), w[2 + i]});
  endfunction

  // mode 0: valid every cycle, 1: toggling, 2: random gaps. Busy window opens after busy_after accepts.
  task automatic drive(input logic [15:0] w[$], input int mode, input int busy_after,
                       input int busy_len);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    bit  acc;
    while (i < w.size()) begin
      case (mode)
        1:       in_valid = ph;
        2:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      ph = !ph;
      in_data = in_valid ? w[i] : 16'($urandom);
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) begin
        i++;
        guard = 0;
        if (busy_after > 0 && i == busy_after && i < w.size()) begin
          kernel_busy = 1'b1;
          in_valid = 1'b1;
          in_data = w[i];
          repeat (busy_len) begin @(posedge clock); #1; end
          kernel_busy = 1'b0;
        end
      end
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL drive_timeout word %0d not accepted, required accept within 200 cycles", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({write_enable, frame_done, frame_error} !== 3'b000 || write_tensor_id !== 16'h0 ||
        write_index !== 16'h0 || write_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b done=%b err=%b id=%h idx=%h data=%h required all 0",
               write_enable, frame_done, frame_error, write_tensor_id, write_index, write_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", in_ready); end
    kernel_busy = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b required 0", in_ready); end
    kernel_busy = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd1, 16'd4, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (st_e.size() != ex.size()) begin errors++; $display("FAIL basic_count got %0d required %0d", st_e.size(), ex.size()); end
    for (int k = 0; k < ex.size() && k < st_e.size() && k + 2 < acc_e.size(); k++) begin
      checks++;
      if (st_id[k] !== ex[k].id || st_ix[k] !== ex[k].idx || st_dt[k] !== ex[k].data || st_e[k] !== acc_e[k + 2]) begin
        errors++;
        $display("FAIL basic_strobe%0d got id=%h idx=%h data=%h edge=%0d required id=%h idx=%h data=%h edge=%0d",
                 k, st_id[k], st_ix[k], st_dt[k], st_e[k], ex[k].id, ex[k].idx, ex[k].data, acc_e[k + 2]);
      end
    end
    checks++;
    if (st_e.size() == 4 && (st_e[1] != st_e[0] + 1 || st_e[3] != st_e[0] + 3)) begin
      errors++; $display("FAIL basic_consecutive got edges %0d..%0d required 4 consecutive", st_e[0], st_e[3]);
    end
    checks++;
    if (dn_e.size() != 1 || dn_e[0] !== acc_e[dp]) begin
      errors++; $display("FAIL basic_done got %0d pulses required 1 at edge %0d", dn_e.size(), acc_e[dp]);
    end
    checks++;
    if (frame_error !== err) begin errors++; $display("FAIL basic_error got %b required %b", frame_error, err); end
    checks++;
    if (write_enable !== 1'b0 || write_data !== 16'h0400 || write_index !== 16'd3 || write_tensor_id !== 16'd1) begin
      errors++;
      $display("FAIL basic_hold got we=%b id=%h idx=%h data=%h required 0/0001/0003/0400",
               write_enable, write_tensor_id, write_index, write_data);
    end
  endtask

  task automatic test_toggle();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd0, 16'd2, 16'hAAAA, 16'h5555};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 1, 0, 0); settle();
    checks++;
    if (st_e.size() != ex.size()) begin errors++; $display("FAIL toggle_count got %0d required %0d", st_e.size(), ex.size()); end
    for (int k = 0; k < ex.size() && k < st_e.size() && k + 2 < acc_e.size(); k++) begin
      checks++;
      if (st_id[k] !== ex[k].id || st_ix[k] !== ex[k].idx || st_dt[k] !== ex[k].data || st_e[k] !== acc_e[k + 2]) begin
        errors++;
        $display("FAIL toggle_strobe%0d got id=%h idx=%h data=%h edge=%0d required id=%h idx=%h data=%h edge=%0d",
                 k, st_id[k], st_ix[k], st_dt[k], st_e[k], ex[k].id, ex[k].idx, ex[k].data, acc_e[k + 2]);
      end
    end
    checks++;
    if (dn_e.size() != 1 || dn_e[0] !== acc_e[dp]) begin
      errors++; $display("FAIL toggle_done got %0d pulses required 1 at edge %0d", dn_e.size(), acc_e[dp]);
    end
  endtask

  task automatic test_bad_id();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd3, 16'd2, 16'h1234, 16'h4321};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (acc_e.size() != 4 || st_e.size() != 0) begin
      errors++; $display("FAIL badid_consume got accepts=%0d strobes=%0d required 4/0", acc_e.size(), st_e.size());
    end
    checks++;
    if (frame_error !== err || dn_e.size() != 1 || dn_e[0] !== acc_e[dp]) begin
      errors++; $display("FAIL badid_flags got err=%b done=%0d required err=%b done=1", frame_error, dn_e.size(), err);
    end
    f = '{16'd2, 16'd1, 16'h0007};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (st_e.size() != 1 || st_id[0] !== ex[0].id || st_ix[0] !== ex[0].idx || st_dt[0] !== ex[0].data) begin
      errors++; $display("FAIL badid_recover got %0d strobes required 1 id=2 idx=0 data=0007", st_e.size());
    end
    checks++;
    if (frame_error !== err) begin errors++; $display("FAIL badid_clear got %b required %b", frame_error, err); end
  endtask

  task automatic test_too_long();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd0, 16'd7};
    for (int i = 0; i < 7; i++) f.push_back(16'($urandom));
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (acc_e.size() != 9 || st_e.size() != 0 || frame_error !== err) begin
      errors++; $display("FAIL toolong got accepts=%0d strobes=%0d err=%b required 9/0/%b",
                         acc_e.size(), st_e.size(), frame_error, err);
    end
    checks++;
    if (dn_e.size() != 1 || dn_e[0] !== acc_e[dp]) begin
      errors++; $display("FAIL toolong_done got %0d pulses required 1 at edge %0d", dn_e.size(), acc_e[dp]);
    end
    f = '{16'd1, 16'd0};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (st_e.size() != 0 || dn_e.size() != 1 || dn_e[0] !== acc_e[dp] || frame_error !== err) begin
      errors++; $display("FAIL zero_len got strobes=%0d done=%0d err=%b required 0/1 at length edge/%b",
                         st_e.size(), dn_e.size(), frame_error, err);
    end
  endtask

  task automatic test_busy();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd2, 16'd5};
    for (int i = 0; i < 5; i++) f.push_back(16'($urandom));
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 4, 10); settle();
    checks++;
    if (busy_cyc != 10 || busy_rdy != 0) begin
      errors++; $display("FAIL busy_stall got busy=%0d ready_high=%0d required 10/0", busy_cyc, busy_rdy);
    end
    checks++;
    if (st_e.size() != ex.size()) begin errors++; $display("FAIL busy_count got %0d required %0d", st_e.size(), ex.size()); end
    for (int k = 0; k < ex.size() && k < st_e.size() && k + 2 < acc_e.size(); k++) begin
      checks++;
      if (st_id[k] !== ex[k].id || st_ix[k] !== ex[k].idx || st_dt[k] !== ex[k].data || st_e[k] !== acc_e[k + 2]) begin
        errors++;
        $display("FAIL busy_strobe%0d got id=%h idx=%h data=%h edge=%0d required id=%h idx=%h data=%h edge=%0d",
                 k, st_id[k], st_ix[k], st_dt[k], st_e[k], ex[k].id, ex[k].idx, ex[k].data, acc_e[k + 2]);
      end
    end
    checks++;
    if (st_e.size() == 5 && st_e[2] < st_e[1] + 11) begin
      errors++; $display("FAIL busy_gap got idx2 edge %0d required >= %0d", st_e[2], st_e[1] + 11);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    f = '{16'd0, 16'd5, 16'h1111, 16'h2222};
    clear_obs(); drive(f, 0, 0, 0);
    checks++;
    if (write_enable !== 1'b1 || write_index !== 16'd1) begin
      errors++; $display("FAIL midrst_pre got we=%b idx=%h required 1/0001", write_enable, write_index);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({write_enable, frame_done, frame_error} !== 3'b000 || write_tensor_id !== 16'h0 ||
        write_index !== 16'h0 || write_data !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs got we=%b idx=%h data=%h required all 0", write_enable, write_index, write_data);
    end
    @(posedge clock); #3 reset_n = 1'b1;
    clear_obs();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (st_e.size() != 0 || dn_e.size() != 0) begin
      errors++; $display("FAIL midrst_quiet got strobes=%0d done=%0d required 0/0", st_e.size(), dn_e.size());
    end
    f = '{16'd1, 16'd1, 16'h0100};
    model(f, ex, err, dp);
    clear_obs(); drive(f, 0, 0, 0); settle();
    checks++;
    if (st_e.size() != 1 || st_id[0] !== ex[0].id || st_ix[0] !== ex[0].idx || st_dt[0] !== ex[0].data ||
        dn_e.size() != 1 || dn_e[0] !== acc_e[dp]) begin
      errors++; $display("FAIL midrst_next got %0d strobes done=%0d required 1 id=1 idx=0 data=0100 done=1",
                         st_e.size(), dn_e.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] f[$];
    exp_t ex[$];
    logic err;
    int dp;
    int n;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 8);
      f = '{16'($urandom_range(0, 4)), 16'(n)};
      for (int i = 0; i < n; i++) f.push_back(16'($urandom));
      model(f, ex, err, dp);
      clear_obs(); drive(f, $urandom_range(0, 2), 0, 0); settle();
      checks++;
      if (acc_e.size() != f.size() || st_e.size() != ex.size()) begin
        errors++; $display("FAIL rand%0d_count got accepts=%0d strobes=%0d required %0d/%0d",
                           r, acc_e.size(), st_e.size(), f.size(), ex.size());
      end
      for (int k = 0; k < ex.size() && k < st_e.size() && k + 2 < acc_e.size(); k++) begin
        checks++;
        if (st_id[k] !== ex[k].id || st_ix[k] !== ex[k].idx || st_dt[k] !== ex[k].data || st_e[k] !== acc_e[k + 2]) begin
          errors++;
          $display("FAIL rand%0d_strobe%0d got id=%h idx=%h data=%h edge=%0d required id=%h idx=%h data=%h edge=%0d",
                   r, k, st_id[k], st_ix[k], st_dt[k], st_e[k], ex[k].id, ex[k].idx, ex[k].data, acc_e[k + 2]);
        end
      end
      checks++;
      if (dn_e.size() != 1 || dn_e[0] !== acc_e[dp] || frame_error !== err) begin
        errors++; $display("FAIL rand%0d_done got done=%0d err=%b required 1/%b", r, dn_e.size(), frame_error, err);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0;
    kernel_busy = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_bad_id();
    test_too_long();
    test_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
